// File: rtl/sram_lockstep_checker_if.sv
// Control, write-data and status bundle of the SRAM lockstep checker.
interface sram_lockstep_checker_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
);
  logic              start;
  logic [1:0]        mode;
  logic              stop;
  logic [DATA_W-1:0] d_i;
  logic              d_valid;
  logic              d_ready;
  logic              inj_en;
  logic [1:0]        inj_ch;
  logic              busy;
  logic              done;
  logic              pass;
  logic              r_o;
  logic [NUM_CH-1:0] fail_mask;
  logic [CNT_W-1:0]  mismatch_cnt;
  logic [ADDR_W-1:0] first_fail_addr;

  modport master (
    output start, mode, stop, d_i, d_valid, inj_en, inj_ch,
    input  d_ready, busy, done, pass, r_o, fail_mask, mismatch_cnt, first_fail_addr
  );

  modport slave (
    input  start, mode, stop, d_i, d_valid, inj_en, inj_ch,
    output d_ready, busy, done, pass, r_o, fail_mask, mismatch_cnt, first_fail_addr
  );
endinterface

// File: rtl/sram_lockstep_checker.sv
// NUM_CH lockstep SRAM channels swept by one address counter; every channel is
// compared against channel 0 through a two-stage read/compare pipeline.
//   state | meaning
//   IDLE  | waiting for start
//   WRITE | one word per accepted d_valid into all channels
//   READ  | one address issued per cycle
//   DRAIN | two cycles while the read/compare pipeline empties
//   DONE  | one-cycle done pulse
module sram_lockstep_checker #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
) (
  input logic                    clk,
  input logic                    rst,
  sram_lockstep_checker_if.slave bus
);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [1:0]        mode_q;
  logic              stop_seen;
  logic              drain_cnt;
  logic [DATA_W-1:0] mem [NUM_CH][2**ADDR_W];
  logic [DATA_W-1:0] rd_data [NUM_CH];
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [NUM_CH-1:0] ch_mm;
  logic              any_mm;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      addr  <= '0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    unique case (state)
      S_IDLE: if (bus.start) begin
        addr_nxt  = '0;
        state_nxt = (bus.mode == 2'd0) ? S_WRITE : S_READ;
      end
      S_WRITE: if (bus.d_valid) begin
        addr_nxt = addr + 1'b1;
        if (addr == ADDR_LAST) state_nxt = S_READ;
      end
      S_READ: begin
        addr_nxt = addr + 1'b1;
        if (addr == ADDR_LAST) state_nxt = S_DRAIN;
      end
      S_DRAIN: if (drain_cnt) begin
        addr_nxt  = '0;
        state_nxt = (mode_q == 2'd2 && !(stop_seen || bus.stop)) ? S_READ : S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.busy    = (state != S_IDLE);
  assign bus.done    = (state == S_DONE);
  assign bus.d_ready = (state == S_WRITE);

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= 2'd0;
      stop_seen <= 1'b0;
      drain_cnt <= 1'b0;
    end else begin
      drain_cnt <= (state == S_DRAIN) ? ~drain_cnt : 1'b0;
      if (state == S_IDLE) begin
        stop_seen <= 1'b0;
        if (bus.start) mode_q <= bus.mode;
      end else if (bus.stop) begin
        stop_seen <= 1'b1;
      end
    end
  end

  // Memory is never cleared; writes are suppressed on a reset edge so an abort is clean.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (!rst && state == S_WRITE && bus.d_valid) begin
        if (bus.inj_en && bus.inj_ch == 2'(c)) mem[c][addr] <= bus.d_i ^ DATA_W'(1);
        else                                   mem[c][addr] <= bus.d_i;
      end
      if (state == S_READ) rd_data[c] <= mem[c][addr];
    end
  end

  always_comb begin
    ch_mm = '0;
    for (int c = 1; c < NUM_CH; c++) ch_mm[c] = (rd_data[c] != rd_data[0]);
  end

  assign any_mm = rd_valid && (|ch_mm);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid            <= 1'b0;
      rd_addr             <= '0;
      bus.r_o             <= 1'b0;
      bus.fail_mask       <= '0;
      bus.mismatch_cnt    <= '0;
      bus.first_fail_addr <= '0;
      bus.pass            <= 1'b0;
    end else begin
      rd_valid <= (state == S_READ);
      rd_addr  <= addr;
      bus.r_o  <= any_mm;
      if (state == S_IDLE && bus.start) begin
        bus.fail_mask       <= '0;
        bus.mismatch_cnt    <= '0;
        bus.first_fail_addr <= '0;
        bus.pass            <= 1'b0;
      end else begin
        if (any_mm) begin
          bus.fail_mask <= bus.fail_mask | ch_mm;
          if (bus.mismatch_cnt == '0) bus.first_fail_addr <= rd_addr;
          if (bus.mismatch_cnt != '1) bus.mismatch_cnt <= bus.mismatch_cnt + 1'b1;
        end
        // Last compare lands in the first DRAIN cycle, so the count is final here.
        if (state == S_DRAIN && state_nxt == S_DONE) bus.pass <= (bus.mismatch_cnt == '0);
      end
    end
  end
endmodule

// File: tb/tb_sram_lockstep_checker.sv
// Randomised bench for sram_lockstep_checker against a pass-level memory model;
// a second instance with a 2-bit counter shares the stimulus to observe saturation.
module tb_sram_lockstep_checker;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int NUM_CH = 3;
  localparam int CNT_W  = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_lockstep_checker_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();
  sram_lockstep_checker_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .CNT_W(2)) bus2 ();

  sram_lockstep_checker #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .CNT_W(CNT_W))
    dut (.clk(clk), .rst(rst), .bus(bus));
  sram_lockstep_checker #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .CNT_W(2))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus2.start   = bus.start;
  assign bus2.mode    = bus.mode;
  assign bus2.stop    = bus.stop;
  assign bus2.d_i     = bus.d_i;
  assign bus2.d_valid = bus.d_valid;
  assign bus2.inj_en  = bus.inj_en;
  assign bus2.inj_ch  = bus.inj_ch;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] m_mem [NUM_CH][DEPTH];
  int                exp_cnt;
  logic [NUM_CH-1:0] exp_mask;
  int                exp_ffa;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check_val({tag, "_busy"}, bus.busy, 0);
    check_val({tag, "_done"}, bus.done, 0);
    check_val({tag, "_pass"}, bus.pass, 0);
    check_val({tag, "_r_o"}, bus.r_o, 0);
    check_val({tag, "_d_ready"}, bus.d_ready, 0);
    check_val({tag, "_mask"}, bus.fail_mask, 0);
    check_val({tag, "_cnt"}, bus.mismatch_cnt, 0);
    check_val({tag, "_ffa"}, bus.first_fail_addr, 0);
  endtask

  // wmode: 0 back-to-back, 1 every other cycle, 2 random gaps/data.
  // inj_sel: 0 none, 1 channel 1 at 0x10 and 0x80, 2 random channel/address.
  task automatic run(input logic [1:0] m, input int wmode, input int inj_sel, input int stop_pass,
                     input int busy_start_a, input int rst_at, input int exp_len);
    int          n, waddr, pass_no;
    logic        v, stop_model, r1, r2, mm;
    logic [31:0] d;
    bus.start = 1'b1;
    bus.mode  = m;
    @(negedge clk);
    bus.start  = 1'b0;
    n          = 1;
    exp_cnt    = 0;
    exp_mask   = '0;
    exp_ffa    = 0;
    stop_model = 1'b0;
    r1         = 1'b0;
    r2         = 1'b0;
    check_val("pass_clr", bus.pass, 0);
    check_val("cnt_clr", bus.mismatch_cnt, 0);
    if (m == 2'd0) begin
      waddr = 0;
      while (waddr < DEPTH) begin
        check_val("busy_wr", bus.busy, 1);
        check_val("d_ready_wr", bus.d_ready, 1);
        check_val("r_o_wr", bus.r_o, 0);
        if (waddr == rst_at) begin
          bus.d_valid = 1'b0;
          rst = 1'b1;
          repeat (2) @(negedge clk);
          rst = 1'b0;
          check_idle_zero("after_rst");
          for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("no_done_after_rst", bus.done, 0);
          end
          return;
        end
        v = (wmode == 0) ? 1'b1 : (wmode == 1) ? !n[0] : ($urandom_range(0, 3) != 0);
        d = (wmode == 2) ? $urandom : waddr * 32'h0101_0101;
        bus.d_valid = v;
        bus.d_i     = d;
        bus.inj_ch  = (inj_sel == 2) ? 2'($urandom_range(0, 3)) : 2'd1;
        bus.inj_en  = (inj_sel == 1) ? (waddr == 16 || waddr == 128) :
                      (inj_sel == 2) ? ($urandom_range(0, 7) == 0) : 1'b0;
        if (v) begin
          for (int k = 0; k < NUM_CH; k++)
            m_mem[k][waddr] = (bus.inj_en && int'(bus.inj_ch) == k) ? (d ^ 32'd1) : d;
          waddr++;
        end
        @(negedge clk);
        n++;
      end
      bus.d_valid = 1'b0;
      bus.inj_en  = 1'b0;
    end
    pass_no = 0;
    do begin
      for (int a = 0; a < DEPTH; a++) begin
        check_val("busy_rd", bus.busy, 1);
        check_val("d_ready_rd", bus.d_ready, 0);
        check_val("done_rd", bus.done, 0);
        check_val("r_o_rd", bus.r_o, r2);
        mm = 1'b0;
        for (int k = 1; k < NUM_CH; k++)
          if (m_mem[k][a] != m_mem[0][a]) begin
            mm          = 1'b1;
            exp_mask[k] = 1'b1;
          end
        if (mm) begin
          if (exp_cnt == 0) exp_ffa = a;
          exp_cnt++;
        end
        r2 = r1;
        r1 = mm;
        bus.start = (a == busy_start_a && pass_no == 0);
        if (bus.start) bus.mode = 2'd0;
        bus.stop = (pass_no == stop_pass && a == 100);
        if (bus.stop) stop_model = 1'b1;
        @(negedge clk);
        n++;
      end
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      for (int i = 0; i < 2; i++) begin
        check_val("busy_drain", bus.busy, 1);
        check_val("done_drain", bus.done, 0);
        check_val("r_o_drain", bus.r_o, r2);
        r2 = r1;
        r1 = 1'b0;
        @(negedge clk);
        n++;
      end
      pass_no++;
    end while (m == 2'd2 && !stop_model && pass_no < 8);
    check_val("done_pulse", bus.done, 1);
    check_val("busy_done", bus.busy, 1);
    check_val("r_o_done", bus.r_o, 0);
    if (exp_len > 0) check_val("done_latency", n, exp_len);
    check_val("pass", bus.pass, (exp_cnt == 0));
    check_val("mismatch_cnt", bus.mismatch_cnt, (exp_cnt > 65535) ? 65535 : exp_cnt);
    check_val("mismatch_cnt_sat", bus2.mismatch_cnt, (exp_cnt > 3) ? 3 : exp_cnt);
    check_val("fail_mask", bus.fail_mask, exp_mask);
    if (exp_cnt != 0) check_val("first_fail_addr", bus.first_fail_addr, exp_ffa);
    @(negedge clk);
    check_val("done_one_cycle", bus.done, 0);
    check_val("busy_idle", bus.busy, 0);
    check_val("pass_hold", bus.pass, (exp_cnt == 0));
  endtask

  initial begin
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.mode    = 2'd0;
    bus.stop    = 1'b0;
    bus.d_i     = '0;
    bus.d_valid = 1'b0;
    bus.inj_en  = 1'b0;
    bus.inj_ch  = 2'd0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    run(2'd0, 0, 0, -1, -1, -1, 515);
    run(2'd0, 1, 0, -1, -1, -1, 771);
    run(2'd0, 0, 1, -1, -1, -1, 515);
    check_val("inj_ffa", bus.first_fail_addr, 32'h10);
    check_val("inj_cnt", bus.mismatch_cnt, 2);
    check_val("inj_mask", bus.fail_mask, 3'b010);
    run(2'd2, 0, 0, 2, -1, -1, 3 * (DEPTH + 2) + 1);
    check_val("scrub_cnt", bus.mismatch_cnt, 6);
    check_val("scrub_cnt_sat", bus2.mismatch_cnt, 3);
    run(2'd3, 0, 0, -1, 50, -1, 259);
    check_val("busy_start_cnt", bus.mismatch_cnt, 2);
    run(2'd0, 2, 2, -1, -1, -1, 0);
    run(2'd0, 2, 2, -1, -1, 77, 0);
    run(2'd1, 0, 0, -1, -1, -1, 259);
    run(2'd2, 0, 0, int'($urandom_range(0, 1)), 30, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
